mem_arbiter: RTL

//   Shares one single-port memory bus between two requesters (port 0: processor,

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory bus between
// two req/ack requesters. Every transaction is registered; read data returns
// with a one-cycle ack after a programmable read latency.
module mem_arbiter #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [3:0]  m0_wr_mask_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_data_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [3:0]  m1_wr_mask_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_data_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_wr_mask_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    output logic        busy_o
);

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    // WAIT runs RD_LATENCY-1 cycles; counter is loaded with that count minus one.
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q;
    logic               lat_we_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [MASK_W-1:0]  win_mask;
    logic [DATA_W-1:0]  win_data;

    logic [ADDR_W-1:0]  mem_addr_d;
    logic               mem_we_d;
    logic [MASK_W-1:0]  mem_wr_mask_d;
    logic [DATA_W-1:0]  mem_data_d;
    logic               m0_ack_d, m1_ack_d;
    logic [DATA_W-1:0]  m0_data_d, m1_data_d;
    logic               busy_d;

    // State register plus grant bookkeeping and read-latency counter
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lat_we_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && state_d == S_ISSUE) begin
                grant_q      <= grant_d;
                last_grant_q <= grant_d;
                lat_we_q     <= win_we;
            end
            if (state_q == S_ISSUE) begin
                cnt_q <= CNT_INIT;
            end else if (state_q == S_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Next-state and round-robin arbitration
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    grant_d = (m0_req_i && m1_req_i) ? ~last_grant_q : m1_req_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (lat_we_q || RD_LATENCY == 1) state_d = S_DONE;
                else                             state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        win_we   = grant_d ? m1_we_i      : m0_we_i;
        win_addr = grant_d ? m1_addr_i    : m0_addr_i;
        win_mask = grant_d ? m1_wr_mask_i : m0_wr_mask_i;
        win_data = grant_d ? m1_data_i    : m0_data_i;

        mem_addr_d    = mem_addr_o;
        mem_wr_mask_d = mem_wr_mask_o;
        mem_data_d    = mem_data_o;
        mem_we_d      = 1'b0;
        m0_ack_d      = 1'b0;
        m1_ack_d      = 1'b0;
        m0_data_d     = m0_data_o;
        m1_data_d     = m1_data_o;
        busy_d        = (state_d != S_IDLE);

        if (state_q == S_IDLE && state_d == S_ISSUE) begin
            mem_addr_d    = win_addr;
            mem_wr_mask_d = win_mask;
            mem_data_d    = win_data;
            mem_we_d      = win_we;
        end else if (state_d == S_DONE) begin
            mem_addr_d    = '0;
            mem_wr_mask_d = '0;
            mem_data_d    = '0;
            m0_ack_d      = ~grant_q;
            m1_ack_d      = grant_q;
            if (!lat_we_q) begin
                if (grant_q) m1_data_d = mem_data_i;
                else         m0_data_d = mem_data_i;
            end
        end
    end

    // Output registers; reset clears the bus at once and aborts any ack
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            mem_addr_o    <= '0;
            mem_we_o      <= 1'b0;
            mem_wr_mask_o <= '0;
            mem_data_o    <= '0;
            m0_ack_o      <= 1'b0;
            m1_ack_o      <= 1'b0;
            m0_data_o     <= '0;
            m1_data_o     <= '0;
            busy_o        <= 1'b0;
        end else begin
            mem_addr_o    <= mem_addr_d;
            mem_we_o      <= mem_we_d;
            mem_wr_mask_o <= mem_wr_mask_d;
            mem_data_o    <= mem_data_d;
            m0_ack_o      <= m0_ack_d;
            m1_ack_o      <= m1_ack_d;
            m0_data_o     <= m0_data_d;
            m1_data_o     <= m1_data_d;
            busy_o        <= busy_d;
        end
    end

endmodule
